// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the legal parameter
// envelope that UART blocks are checked against when they are elaborated.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 9;
  localparam int OVERSAMPLE_MIN = 4;
  localparam int OVERSAMPLE_MAX = 64;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset value
// is a parameter so idle-high serial lines come out of reset in their idle state.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: oversampled start/data/parity/stop framing feeding a one-deep
// holding stage with valid/ready handoff and overrun reporting.
//
// state     | meaning
// RX_IDLE   | line idle, waiting for a synchronized low
// RX_START  | qualifying the start bit at its mid-point
// RX_DATA   | shifting in data bits, LSB first
// RX_PARITY | sampling the parity bit
// RX_STOP   | sampling stop bits, frame delivered on the last one
// RX_BREAK  | line still low after the frame, waiting for it to go high
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_Rx_Data,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Rx_Valid,
  input  logic                 i_Rx_Ready,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun,
  output logic                 o_Busy
);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_rx_engine: DATA_BITS must be within 5..9");
  end
  if (OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX || (OVERSAMPLE % 2) != 0)
  begin : g_bad_oversample
    $error("uart_rx_engine: OVERSAMPLE must be even and within 4..64");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_rx_engine: STOP_BITS must be 1 or 2");
  end
  if (PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_rx_engine: PARITY_EN and PARITY_ODD must be 0 or 1");
  end

  localparam int SAMPLE_W = $clog2(OVERSAMPLE);
  localparam int BIT_W    = $clog2(DATA_BITS);

  localparam logic [SAMPLE_W-1:0] HALF_TC = SAMPLE_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMPLE_W-1:0] FULL_TC = SAMPLE_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]    DATA_TC = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]    STOP_TC = BIT_W'(STOP_BITS - 1);
  localparam logic                ODD_BIT = (PARITY_ODD != 0);
  localparam logic                HAS_PAR = (PARITY_EN != 0);

  rx_state_t            state;
  logic [SAMPLE_W-1:0]  sample_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_err;
  logic                 frame_err;
  logic                 line_s;
  logic                 bit_tc;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (i_Rx_Data),
    .q       (line_s)
  );

  assign bit_tc = (sample_cnt == FULL_TC);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RX_IDLE;
      sample_cnt   <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Rx_Valid   <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Overrun    <= 1'b0;
      o_Busy       <= 1'b0;
    end else begin
      // Acceptance first; a frame landing this cycle overrides it below.
      if (o_Rx_Valid && i_Rx_Ready) begin
        o_Rx_Valid <= 1'b0;
        o_Overrun  <= 1'b0;
      end

      case (state)
        RX_IDLE: begin
          if (!line_s) begin
            state      <= RX_START;
            sample_cnt <= '0;
            o_Busy     <= 1'b1;
          end
        end

        RX_START: begin
          if (sample_cnt == HALF_TC) begin
            sample_cnt <= '0;
            bit_cnt    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (line_s) begin
              state  <= RX_IDLE;
              o_Busy <= 1'b0;
            end else begin
              state <= RX_DATA;
            end
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end

        RX_DATA: begin
          if (bit_tc) begin
            sample_cnt <= '0;
            shift_reg  <= {line_s, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == DATA_TC) begin
              bit_cnt <= '0;
              state   <= HAS_PAR ? RX_PARITY : RX_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end

        RX_PARITY: begin
          if (bit_tc) begin
            sample_cnt <= '0;
            parity_err <= (^shift_reg) ^ line_s ^ ODD_BIT;
            state      <= RX_STOP;
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end

        RX_STOP: begin
          if (bit_tc) begin
            sample_cnt <= '0;
            if (bit_cnt == STOP_TC) begin
              bit_cnt      <= '0;
              o_Rx_Byte    <= shift_reg;
              o_Parity_Err <= parity_err;
              o_Frame_Err  <= frame_err | ~line_s;
              o_Rx_Valid   <= 1'b1;
              o_Overrun    <= o_Rx_Valid && !i_Rx_Ready;
              if (line_s) begin
                state  <= RX_IDLE;
                o_Busy <= 1'b0;
              end else begin
                state <= RX_BREAK;
              end
            end else begin
              frame_err <= frame_err | ~line_s;
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end

        RX_BREAK: begin
          if (line_s) begin
            state  <= RX_IDLE;
            o_Busy <= 1'b0;
          end
        end

        default: begin
          state  <= RX_IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Randomized frame-level bench: two receivers (8N1 and 8E2) fed serial frames,
// delivered frames compared against values computed from the framing rules.
module tb_uart_rx_engine;

  localparam int OS0 = 16;
  localparam int OS1 = 8;

  logic       clk;
  logic       reset_n;
  logic       rx0, ready0, valid0, perr0, ferr0, ovr0, busy0;
  logic       rx1, ready1, valid1, perr1, ferr1, ovr1, busy1;
  logic [7:0] byte0, byte1;

  int checks = 0;
  int errors = 0;

  // Captured accepted frames: {overrun, frame_err, parity_err, data}
  logic [10:0] cap0 [64];
  logic [10:0] cap1 [64];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  int vhigh0 = 0;

  uart_rx_engine #(.DATA_BITS(8), .OVERSAMPLE(OS0), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .i_Rx_Data(rx0), .o_Rx_Byte(byte0),
    .o_Rx_Valid(valid0), .i_Rx_Ready(ready0), .o_Parity_Err(perr0),
    .o_Frame_Err(ferr0), .o_Overrun(ovr0), .o_Busy(busy0)
  );

  uart_rx_engine #(.DATA_BITS(8), .OVERSAMPLE(OS1), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .i_Rx_Data(rx1), .o_Rx_Byte(byte1),
    .o_Rx_Valid(valid1), .i_Rx_Ready(ready1), .o_Parity_Err(perr1),
    .o_Frame_Err(ferr1), .o_Overrun(ovr1), .o_Busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid0) vhigh0 <= vhigh0 + 1;
    if (valid0 && ready0) begin
      cap0[wr0] <= {ovr0, ferr0, perr0, byte0};
      wr0 <= wr0 + 1;
    end
    if (valid1 && ready1) begin
      cap1[wr1] <= {ovr1, ferr1, perr1, byte1};
      wr1 <= wr1 + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [10:0] rec(input logic [7:0] d, input logic pe, input logic fe,
                                      input logic ov);
    return {ov, fe, pe, d};
  endfunction

  task automatic expect0(input string tag, input logic [10:0] exp);
    check_eq({tag, " count"}, wr0 - rd0, 1);
    check_eq(tag, cap0[rd0], exp);
    rd0 = wr0;
  endtask

  task automatic expect1(input string tag, input logic [10:0] exp);
    check_eq({tag, " count"}, wr1 - rd1, 1);
    check_eq(tag, cap1[rd1], exp);
    rd1 = wr1;
  endtask

  task automatic send0(input logic [7:0] d, input logic stop);
    rx0 = 1'b0;
    tick(OS0);
    for (int i = 0; i < 8; i++) begin
      rx0 = d[i];
      tick(OS0);
    end
    rx0 = stop;
    tick(OS0);
  endtask

  task automatic send1(input logic [7:0] d, input logic pbit, input logic s1, input logic s2);
    rx1 = 1'b0;
    tick(OS1);
    for (int i = 0; i < 8; i++) begin
      rx1 = d[i];
      tick(OS1);
    end
    rx1 = pbit; tick(OS1);
    rx1 = s1;   tick(OS1);
    rx1 = s2;   tick(OS1);
    rx1 = 1'b1;
    tick(6);
  endtask

  initial begin
    logic [7:0] d;
    logic       pb, s1, s2, busy_all;
    int         vh;

    reset_n = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1;
    ready0 = 1'b1; ready1 = 1'b1;
    tick(3);
    check_eq("reset byte0", byte0, 8'h00);
    check_eq("reset flags0", {valid0, perr0, ferr0, ovr0, busy0}, 5'b0);
    check_eq("reset flags1", {valid1, perr1, ferr1, ovr1, busy1}, 5'b0);
    reset_n = 1'b1;
    tick(3);

    // Basic 8N1 frame, single-cycle valid pulse
    vh = vhigh0;
    send0(8'hA5, 1'b1);
    tick(4);
    expect0("frame A5", rec(8'hA5, 1'b0, 1'b0, 1'b0));
    check_eq("valid width", vhigh0 - vh, 1);

    for (int k = 0; k < 6; k++) begin
      d = 8'($urandom_range(0, 255));
      send0(d, 1'b1);
      tick(4);
      expect0("rand frame", rec(d, 1'b0, 1'b0, 1'b0));
    end

    // Even parity: parity error is the XOR of data and parity bit
    send1(8'h03, 1'b1, 1'b1, 1'b1);
    expect1("parity 03/1", rec(8'h03, 1'b1, 1'b0, 1'b0));
    send1(8'h03, 1'b0, 1'b1, 1'b1);
    expect1("parity 03/0", rec(8'h03, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 8; k++) begin
      d  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      send1(d, pb, s1, s2);
      expect1("rand parity frame", rec(d, ^d ^ pb, ~(s1 & s2), 1'b0));
    end

    // Stop bit low then line held low: frame error, busy until line recovers
    d = 8'($urandom_range(0, 255));
    send0(d, 1'b0);
    busy_all = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      busy_all = busy_all & busy0;
    end
    check_eq("break busy", busy_all, 1'b1);
    expect0("frame err", rec(d, 1'b0, 1'b1, 1'b0));
    rx0 = 1'b1;
    tick(4);
    check_eq("break exit busy", busy0, 1'b0);

    // Short low glitch is rejected as a false start
    vh = vhigh0;
    rx0 = 1'b0; tick(4);
    rx0 = 1'b1; tick(20);
    check_eq("glitch no frame", wr0 - rd0, 0);
    check_eq("glitch no valid", vhigh0 - vh, 0);
    check_eq("glitch idle", busy0, 1'b0);

    // Overrun: second frame overwrites an unaccepted first
    ready0 = 1'b0;
    send0(8'h11, 1'b1);
    tick(4);
    check_eq("hold 11", {valid0, ovr0, byte0}, {1'b1, 1'b0, 8'h11});
    send0(8'h22, 1'b1);
    tick(4);
    check_eq("overrun 22", {valid0, ovr0, perr0, ferr0, byte0}, {4'b1100, 8'h22});
    check_eq("no accept while not ready", wr0 - rd0, 0);
    ready0 = 1'b1;
    tick(1);
    ready0 = 1'b0;
    tick(2);
    expect0("accept overrun", rec(8'h22, 1'b0, 1'b0, 1'b1));
    check_eq("cleared after accept", {valid0, ovr0}, 2'b00);
    ready0 = 1'b1;
    tick(2);

    // Reset during bit 4 of 0x5A discards the partial frame
    d = 8'h5A;
    rx0 = 1'b0;
    tick(OS0);
    for (int i = 0; i < 4; i++) begin
      rx0 = d[i];
      tick(OS0);
    end
    rx0 = d[4];
    tick(5);
    check_eq("mid frame busy", busy0, 1'b1);
    reset_n = 1'b0;
    tick(2);
    check_eq("mid reset byte", byte0, 8'h00);
    check_eq("mid reset flags", {valid0, perr0, ferr0, ovr0, busy0}, 5'b0);
    reset_n = 1'b1;
    rx0 = 1'b1;
    tick(30);
    check_eq("no partial frame", wr0 - rd0, 0);
    check_eq("idle after reset", busy0, 1'b0);
    send0(8'hC3, 1'b1);
    tick(4);
    expect0("frame C3", rec(8'hC3, 1'b0, 1'b0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_engine.md
UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, clk cycles per bit; legal range 4..64, even.
REQ-003 SHALL have parameter PARITY_EN, default 0; 1 = one parity bit follows the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0; 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal values 1 or 2.
REQ-006 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port i_Rx_Data  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port o_Rx_Byte  output  DATA_BITS  received data, LSB = first bit on the line.
REQ-010 SHALL have port o_Rx_Valid  output  1  o_Rx_Byte and flags hold a frame.
REQ-011 SHALL have port i_Rx_Ready  input  1  consumer accepts the frame when high with o_Rx_Valid.
REQ-012 SHALL have port o_Parity_Err  output  1  parity mismatch for the held frame.
REQ-013 SHALL have port o_Frame_Err  output  1  a stop bit sampled low for the held frame.
REQ-014 SHALL have port o_Overrun  output  1  an unaccepted frame was overwritten.
REQ-015 SHALL have port o_Busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL pass i_Rx_Data through a 2-flop synchronizer; the FSM sees only the synchronized line.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-018 In IDLE, a synchronized low SHALL move the FSM to START with the bit counter cleared.
REQ-019 In START, the line SHALL be sampled when the counter reaches OVERSAMPLE/2-1: low -> DATA with counter cleared; high -> IDLE as a glitch, with no output change.
REQ-020 In DATA, PARITY and STOP, each bit SHALL be sampled when the counter reaches OVERSAMPLE-1; the counter then SHALL wrap to 0.
REQ-021 Data bits SHALL be shifted in LSB first; after DATA_BITS samples the FSM SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-022 Parity error SHALL equal XOR(data bits, parity bit, PARITY_ODD) = 1, and SHALL be 0 when PARITY_EN=0.
REQ-023 STOP SHALL sample STOP_BITS bits; frame error SHALL be set if any sampled stop bit is 0.
REQ-024 On the final stop sample, data and flags SHALL be registered into the output stage, and o_Rx_Valid SHALL rise on the next cycle (latency 1 clk from final sample).
REQ-025 After the final stop sample, the FSM SHALL go to IDLE if the line is high, else to BREAK; BREAK SHALL return to IDLE only when the synchronized line is high.
REQ-026 o_Rx_Valid SHALL stay high, with o_Rx_Byte and all flags stable, until a cycle with i_Rx_Ready=1 occurs; it then SHALL clear on the next edge.
REQ-027 If a frame completes while o_Rx_Valid=1 and i_Rx_Ready=0, the new frame SHALL overwrite the output and o_Overrun SHALL be set to 1.
REQ-028 If a frame completes in the same cycle as an acceptance, the new frame SHALL load, o_Rx_Valid SHALL stay 1 and o_Overrun SHALL be 0.
REQ-029 o_Overrun SHALL clear on acceptance.
REQ-030 Bit and sample counters SHALL be sized with $clog2 of their maxima and SHALL never wrap beyond the terminal count.

Reset
REQ-031 While reset_n=0: FSM SHALL be in IDLE, counters and shift register 0, both synchronizer flops 1.
REQ-032 While reset_n=0: o_Rx_Byte SHALL be 0, and o_Rx_Valid, o_Parity_Err, o_Frame_Err, o_Overrun and o_Busy SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; after release, reception SHALL resume only on a new falling edge.

Structure
REQ-034 Package uart_pkg SHALL hold the rx state enum and the parameter legality limits.
REQ-035 The synchronizer SHALL be a sub-module uart_sync2 (reset value 1, shared with future blocks).
REQ-036 Parameter legality SHALL be checked at elaboration.

Verification
REQ-037 8N1 frame 0xA5 at OVERSAMPLE=16, i_Rx_Ready=1 -> o_Rx_Valid 1 cycle, o_Rx_Byte=0xA5, all flags 0.
REQ-038 PARITY_EN=1, PARITY_ODD=0, byte 0x03 with parity bit 1 -> o_Parity_Err=1; parity bit 0 -> o_Parity_Err=0.
REQ-039 Stop bit held 0, then line low 40 clk -> o_Frame_Err=1, o_Busy stays high until the line returns high.
REQ-040 Low glitch of 4 clk at OVERSAMPLE=16 -> no o_Rx_Valid, FSM back in IDLE.
REQ-041 Frames 0x11 then 0x22 with i_Rx_Ready=0 -> o_Rx_Byte=0x22, o_Overrun=1; one i_Rx_Ready pulse clears both.
REQ-042 reset_n pulsed low during bit 4 of 0x5A, then full frame 0xC3 -> only 0xC3 delivered, no flags.
